// File: rtl/xs3_serial_decoder.sv
// xs3_serial_decoder: bit-serial Excess-3 to BCD decoder with a borrow FSM, illegal-code
// flagging and a saturating error-frame counter.
module xs3_serial_decoder #(
  parameter int OFFSET   = 3,
  parameter int MAX_CODE = 12,
  parameter int ERRW     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            x_i,
  input  logic            x_valid_i,
  input  logic            start_i,
  output logic            s_o,
  output logic            s_valid_o,
  output logic [3:0]      d_o,
  output logic            d_valid_o,
  output logic            err_o,
  output logic [ERRW-1:0] err_cnt_o
);
  // encoding is {bit index, borrow}; bit 0 never carries a borrow
  typedef enum logic [2:0] {
    BIT0   = 3'b000,
    BIT1   = 3'b010,
    BIT1_B = 3'b011,
    BIT2   = 3'b100,
    BIT2_B = 3'b101,
    BIT3   = 3'b110,
    BIT3_B = 3'b111
  } state_e;
  localparam logic [3:0] OFF  = 4'(OFFSET);
  localparam logic [3:0] MAXC = 4'(MAX_CODE);
  state_e          state_q, state_d;
  logic [2:0]      shift_q, shift_d, res_q, res_d;
  logic            s_q, s_d, sv_q, sv_d, dv_q, dv_d, err_q, err_d;
  logic [3:0]      d_q, d_d;
  logic [ERRW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx;
  logic            bin, k, s, bout, illegal;
  logic [3:0]      code;
  always_comb begin
    idx     = start_i ? 2'd0 : state_q[2:1];
    bin     = start_i ? 1'b0 : state_q[0];
    k       = OFF[idx];
    s       = x_i ^ k ^ bin;
    bout    = (~x_i & (k | bin)) | (k & bin);
    code    = {x_i, shift_q};
    // at bit 3 the offset bit is 0, so a surviving borrow means code < OFFSET
    illegal = bout || (code > MAXC);
    state_d = state_q;
    shift_d = shift_q;
    res_d   = res_q;
    s_d     = s_q;
    sv_d    = x_valid_i;
    d_d     = d_q;
    dv_d    = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (x_valid_i) begin
      s_d     = s;
      state_d = state_e'({idx + 2'd1, bout & (idx != 2'd3)});
      dv_d    = (idx == 2'd3);
      if (idx != 2'd3) begin
        shift_d[idx] = x_i;
        res_d[idx]   = s;
      end else begin
        d_d   = illegal ? 4'd0 : {s, res_q};
        err_d = illegal;
        cnt_d = (illegal && cnt_q != '1) ? cnt_q + ERRW'(1) : cnt_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BIT0;
      shift_q <= '0;
      res_q   <= '0;
      s_q     <= 1'b0;
      sv_q    <= 1'b0;
      d_q     <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      res_q   <= res_d;
      s_q     <= s_d;
      sv_q    <= sv_d;
      d_q     <= d_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign s_o       = s_q;
  assign s_valid_o = sv_q;
  assign d_o       = d_q;
  assign d_valid_o = dv_q;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;
endmodule

// File: tb/tb_xs3_serial_decoder.sv
// tb_xs3_serial_decoder: directed scoreboard bench; expected serial bits and frame results
// are queued when driven and checked when the decoder emits them.
module tb_xs3_serial_decoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       x_i = 1'b0, x_valid_i = 1'b0, start_i = 1'b0;
  logic       s_o, s_valid_o, d_valid_o, err_o;
  logic [3:0] d_o;
  logic [7:0] err_cnt_o;
  int         checks = 0, failures = 0, dv_cnt = 0, n0;
  logic        sq[$];
  logic [12:0] fq[$];
  logic [7:0]  err_m = 8'd0;

  xs3_serial_decoder dut (
    .clk(clk), .rst_n(rst_n), .x_i(x_i), .x_valid_i(x_valid_i), .start_i(start_i),
    .s_o(s_o), .s_valid_o(s_valid_o), .d_o(d_o), .d_valid_o(d_valid_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drives nbits of code LSB first; a full frame also queues its expected {err_cnt, err, d}
  task automatic send_code(input logic [3:0] code, input int nbits, input logic st, input int gap);
    logic [3:0] diff;
    logic       bad;
    diff = code - 4'd3;
    bad  = (code < 4'd3) || (code > 4'd12);
    for (int j = 0; j < nbits; j++) begin
      x_i       = code[j];
      x_valid_i = 1'b1;
      start_i   = st && (j == 0);
      sq.push_back(diff[j]);
      if (j == 3) begin
        if (bad && err_m != 8'hff) err_m++;
        fq.push_back({err_m, bad, bad ? 4'h0 : diff});
      end
      @(posedge clk);
      #1;
      x_valid_i = 1'b0;
      start_i   = 1'b0;
      if (j < nbits - 1) idle(gap);
    end
  endtask

  logic        exp_s;
  logic [12:0] exp_f;
  always @(negedge clk) if (rst_n) begin
    if (s_valid_o) begin
      exp_s = (sq.size() != 0) ? sq.pop_front() : 1'bx;
      chk("s_bit", 13'(s_o), (sq.size() >= 0 && exp_s !== 1'bx) ? 13'(exp_s) : 13'h1fff);
    end
    if (d_valid_o) begin
      dv_cnt++;
      exp_f = (fq.size() != 0) ? fq.pop_front() : 13'h1fff;
      chk("frame", {err_cnt_o, err_o, d_o}, exp_f);
    end
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_outs", {8'd0, s_o, s_valid_o, d_o, d_valid_o, err_o}, 13'd0);
    chk("rst_cnt", 13'(err_cnt_o), 13'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    // 1: reset mid-frame, then a fresh frame
    send_code(4'b1011, 2, 1'b0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {8'd0, s_o, s_valid_o, d_o, d_valid_o, err_o}, 13'd0);
    chk("mid_rst_cnt", 13'(err_cnt_o), 13'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_code(4'b0101, 4, 1'b0, 0);
    idle(2);
    chk("t1_d", 13'(d_o), 13'd2);
    // 2: 1011 -> 8
    send_code(4'b1011, 4, 1'b0, 0);
    idle(2);
    chk("t2_d", {8'd0, err_o, d_o}, 13'h008);
    // 3: back-to-back 0011, 1100
    send_code(4'b0011, 4, 1'b0, 0);
    send_code(4'b1100, 4, 1'b0, 0);
    idle(2);
    chk("t3_d", 13'(d_o), 13'd9);
    // 4: two illegal codes then a legal one
    send_code(4'b0001, 4, 1'b0, 0);
    send_code(4'b1101, 4, 1'b0, 0);
    idle(1);
    chk("t4_err", {err_cnt_o, err_o, d_o}, {8'd2, 1'b1, 4'd0});
    send_code(4'b0100, 4, 1'b0, 0);
    idle(2);
    chk("t4_legal", {err_cnt_o, err_o, d_o}, {8'd2, 1'b0, 4'd1});
    // 5: gaps of 3 idle cycles between bits
    n0 = dv_cnt;
    send_code(4'b1000, 4, 1'b0, 3);
    idle(2);
    chk("t5_dv", 13'(dv_cnt - n0), 13'd1);
    chk("t5_d", 13'(d_o), 13'd5);
    // 6: START drops a partial frame
    n0 = dv_cnt;
    send_code(4'b1011, 2, 1'b0, 0);
    send_code(4'b0111, 4, 1'b1, 0);
    idle(2);
    chk("t6_dv", 13'(dv_cnt - n0), 13'd1);
    chk("t6_d", 13'(d_o), 13'd4);
    repeat (260) send_code(4'hf, 4, 1'b0, 0);
    idle(2);
    chk("sat_cnt", {err_cnt_o, err_o, d_o}, {8'hff, 1'b1, 4'd0});
    send_code(4'b0100, 4, 1'b0, 0);
    send_code(4'b0000, 4, 1'b0, 0);
    idle(2);
    chk("sat_hold", {err_cnt_o, err_o, d_o}, {8'hff, 1'b1, 4'd0});
    chk("sq_empty", 13'(sq.size()), 13'd0);
    chk("fq_empty", 13'(fq.size()), 13'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
